// File: rtl/fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared constants and types for the FIFO read-side stream adapter.
//   DATA_WIDTH_DEF : default width of FIFO read data / stream data
//   SKID_DEPTH     : number of output buffer entries (words absorbed on stall)
//   occ_t          : buffer occupancy, legal values 0..SKID_DEPTH
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int SKID_DEPTH     = 2;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/sync_fifo_stream_reader_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_stream_reader_if
// Bundles the FIFO read port and the outgoing valid/ready stream.
//   fifo_empty, fifo_r_en, fifo_data : FIFO read side (data registered, valid
//                                      the cycle after an accepted pop)
//   m_valid, m_ready, m_data         : downstream stream
// Modports:
//   master : the reader (pops the FIFO, drives the stream)
//   slave  : the environment (FIFO + downstream consumer)
// -----------------------------------------------------------------------------
interface sync_fifo_stream_reader_if
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                  fifo_empty;
    logic                  fifo_r_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_r_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_r_en,
        input  m_valid,
        input  m_data
    );

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid_buf
// Two-entry in-order buffer (head/tail registers) between the FIFO read data
// and the stream output.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : capture push_data at this edge
//   push_data  : word to capture
//   pop        : head word leaves at this edge
//   occ        : number of buffered words (0..2)
//   head_data  : oldest buffered word
// The caller guarantees no push when full and no pop when empty.
// -----------------------------------------------------------------------------
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    occ_t                  occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = push_data;
                else               tail_d = push_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the head advances and the new word
                // lands behind whatever remains.
                if (occ_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the two data registers are reset as well so m_data reads 0 while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            occ_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = head_q;

endmodule

// File: rtl/sync_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// sync_fifo_stream_reader
// Consumer end of a synchronous FIFO with registered read data. Pops the FIFO
// whenever the output buffer can take the word, tracks the single in-flight
// read, and presents buffered words as a valid/ready stream at 1 word/cycle.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   bus (master)  : fifo_empty/fifo_r_en/fifo_data and m_valid/m_ready/m_data
//   words_out     : delivered word count (saturating)
//   stall_cycles  : cycles with m_valid && !m_ready (saturating)
// Build option: FIFO_RD_STATS_EN enables the two statistics counters; without
// it both statistics outputs are tied to 0.
// -----------------------------------------------------------------------------
module sync_fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int STAT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    sync_fifo_stream_reader_if.master     bus,
    output logic [STAT_WIDTH-1:0]         words_out,
    output logic [STAT_WIDTH-1:0]         stall_cycles
);

    occ_t                  occ;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  inflight_q, inflight_d;
    logic                  deliver;
    logic [2:0]            level_next;

    assign deliver = bus.m_valid && bus.m_ready;

    // Projected occupancy after this edge; m_ready feeds fifo_r_en directly so
    // a word leaving this cycle frees room for a pop in the same cycle.
    assign level_next = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, deliver};

    assign bus.fifo_r_en = !rst && !bus.fifo_empty && (level_next < 3'(SKID_DEPTH));
    assign inflight_d    = bus.fifo_r_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight_q <= 1'b0;
        else     inflight_q <= inflight_d;
    end

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (bus.fifo_data),
        .pop       (deliver),
        .occ       (occ),
        .head_data (head_data)
    );

    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = head_data;

    buffer_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        ({1'b0, occ} + {2'b00, inflight_q}) <= 3'(SKID_DEPTH)
    );

`ifdef FIFO_RD_STATS_EN
    logic [STAT_WIDTH-1:0] words_q, words_d;
    logic [STAT_WIDTH-1:0] stall_q, stall_d;

    always_comb begin
        words_d = words_q;
        stall_d = stall_q;
        if (deliver && (words_q != '1))
            words_d = words_q + STAT_WIDTH'(1);
        if (bus.m_valid && !bus.m_ready && (stall_q != '1))
            stall_d = stall_q + STAT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            words_q <= words_d;
            stall_q <= stall_d;
        end
    end

    assign words_out    = words_q;
    assign stall_cycles = stall_q;
`else
    assign words_out    = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_stream_reader
// Directed bench: a FIFO model with registered read data feeds the DUT; a
// negedge monitor records delivered words, which are compared with the words
// loaded. Statistics are checked against hand-computed values in either build.
// -----------------------------------------------------------------------------
module tb_sync_fifo_stream_reader;

    localparam int DW     = 8;
    localparam int STAT_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [STAT_W-1:0] words_out;
    logic [STAT_W-1:0] stall_cycles;

    sync_fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    sync_fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .STAT_WIDTH (STAT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .words_out    (words_out),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic [DW-1:0] mem [0:127];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            pop_count = 0;
    int            pop_while_empty = 0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    initial bus.fifo_data = '0;

    always @(posedge clk) begin
        if (bus.fifo_r_en) begin
            if (rd_ptr == wr_ptr) begin
                pop_while_empty <= pop_while_empty + 1;
            end else begin
                bus.fifo_data <= mem[rd_ptr];
                rd_ptr        <= rd_ptr + 1;
                pop_count     <= pop_count + 1;
            end
        end
    end

    // ---------------- output monitor ----------------
    logic [DW-1:0] got_q [$];
    logic [DW-1:0] exp_q [$];

    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready)
            got_q.push_back(bus.m_data);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_valid(input string tag);
        int budget;
        budget = 20;
        while (!bus.m_valid && budget > 0) begin
            step();
            budget--;
        end
        check({tag, "_valid_timeout"}, bus.m_valid, 1'b1);
    endtask

    initial begin
        int pc0;
        bus.m_ready = 1'b0;

        // ---- 1: reset state, preload, full-throughput drain ----
        load(8'h08); load(8'h13); load(8'hA5); load(8'h3C);
        step(2);
        check("rst_m_valid",   bus.m_valid,   1'b0);
        check("rst_m_data",    bus.m_data,    8'h00);
        check("rst_fifo_r_en", bus.fifo_r_en, 1'b0);
        check("rst_words",     words_out,     4'h0);
        rst         = 1'b0;
        bus.m_ready = 1'b1;
        #1;
        check("t1_first_pop_req", bus.fifo_r_en, 1'b1);
        step();
        check("t1_valid_after_pop", bus.m_valid, 1'b0);
        step();
        check("t1_valid_2nd_edge", bus.m_valid, 1'b1);
        check("t1_d0", bus.m_data, 8'h08);
        step();
        check("t1_d1", bus.m_data, 8'h13);
        step();
        check("t1_d2", bus.m_data, 8'hA5);
        check("t1_ren_empty", bus.fifo_r_en, 1'b0);
        step();
        check("t1_d3", bus.m_data, 8'h3C);
        step();
        check("t1_valid_drop", bus.m_valid, 1'b0);
        compare_stream("t1");

        // ---- 2: backpressure, exactly two pops then hold ----
        bus.m_ready = 1'b0;
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        pc0 = pop_count;
        step(3);
        check("t2_hold_early", bus.m_data, 8'h11);
        step(3);
        check("t2_pops", pop_count - pc0, 2);
        check("t2_valid", bus.m_valid, 1'b1);
        check("t2_hold", bus.m_data, 8'h11);
        check("t2_no_ren", bus.fifo_r_en, 1'b0);
        bus.m_ready = 1'b1;
        step(8);
        compare_stream("t2");

        // ---- 3: alternating ready over 20 random words ----
        for (int i = 0; i < 20; i++) load(DW'($urandom_range(0, 255)));
        for (int i = 0; i < 60; i++) begin
            bus.m_ready = (i % 2 == 0);
            step();
        end
        bus.m_ready = 1'b1;
        step(6);
        compare_stream("t3");
        check("t3_pop_empty", pop_while_empty, 0);

        // ---- 4: async reset mid-stream discards buffered/in-flight words ----
        for (int i = 0; i < 12; i++) load(8'h60 + DW'(i));
        step(4);
        check("t4_pre_count", got_q.size(), 2);
        check("t4_pre_w0", got_q[0], 8'h60);
        check("t4_pre_w1", got_q[1], 8'h61);
        check("t4_pre_inflight", bus.m_valid && !bus.fifo_empty, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("t4_rst_valid", bus.m_valid,   1'b0);
        check("t4_rst_data",  bus.m_data,    8'h00);
        check("t4_rst_ren",   bus.fifo_r_en, 1'b0);
        step(2);
        check("t4_rst_ren_held", bus.fifo_r_en, 1'b0);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        for (int i = rd_ptr; i < wr_ptr; i++) exp_q.push_back(mem[i]);
        check("t4_words_lost", exp_q.size() < 10, 1'b1);
        step(16);
        compare_stream("t4");

        // ---- 5: statistics (10 words, 5 stalls, then saturation) ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) load(8'hC0 + DW'(i));
        wait_valid("t5");
        bus.m_ready = 1'b0;
        step(5);
        check("t5_stall_hold", bus.m_data, 8'hC0);
        bus.m_ready = 1'b1;
        step(15);
        compare_stream("t5");
`ifdef FIFO_RD_STATS_EN
        check("t5_words", words_out,    4'hA);
        check("t5_stall", stall_cycles, 4'h5);
`else
        check("t5_words_off", words_out,    4'h0);
        check("t5_stall_off", stall_cycles, 4'h0);
`endif
        for (int i = 0; i < 10; i++) load(8'hD0 + DW'(i));
        step(15);
        compare_stream("t5b");
`ifdef FIFO_RD_STATS_EN
        check("t5_words_sat", words_out,    4'hF);
        check("t5_stall_end", stall_cycles, 4'h5);
`else
        check("t5_words_sat_off", words_out,    4'h0);
        check("t5_stall_end_off", stall_cycles, 4'h0);
`endif
        check("final_pop_empty", pop_while_empty, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
